lpddr4_cmd_arbiter: RTL and testbench

- Sits directly downstream of the refresher. Merges its command stream with the bank-machine read/write command stream into one DRAM command slot per cycle.
- Refresh has priority, but a read/write burst already granted is never split; a burst ends on its cmd_last.
- The granted command is registered and driven as active-low DFI-style command signals toward the PHY.
- All input command streams are cmd_rw_interface-style: valid/ready/last plus payload a, ba, cas, ras, we.

---
 rtl/lpddr4_cmd_arbiter_pkg.sv | 42 ++++
 rtl/lpddr4_cmd_arbiter_dfi_cmd_reg.sv | 45 ++++
 rtl/lpddr4_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_lpddr4_cmd_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lpddr4_cmd_arbiter_pkg.sv
// Shared memory-controller types: arbiter states, command payload and the
// active-low DFI command word with its NOP value and encoder.
package lpddr4_cmd_arbiter_pkg;

    // Controller-wide address and bank widths used by the shared payload type.
    localparam int MC_ADDR_W = 17;
    localparam int MC_BA_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REF  = 2'd1,
        RW   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [MC_ADDR_W-1:0] a;
        logic [MC_BA_W-1:0]   ba;
        logic                 cas;
        logic                 ras;
        logic                 we;
    } cmd_payload_t;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } dfi_cmd_t;

    localparam dfi_cmd_t DFI_NOP = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};

    // Active-high payload command bits to a selected active-low DFI command.
    function automatic dfi_cmd_t encode_dfi_cmd(input cmd_payload_t p);
        dfi_cmd_t c;
        c.cs_n  = 1'b0;
        c.ras_n = ~p.ras;
        c.cas_n = ~p.cas;
        c.we_n  = ~p.we;
        return c;
    endfunction

endpackage

// File: rtl/lpddr4_cmd_arbiter_dfi_cmd_reg.sv
// Registered payload-to-DFI encoder. A cycle with an accepted command drives
// it onto the DFI bus one cycle later; any other cycle produces a NOP while
// address and bank keep their last values.
module lpddr4_dfi_cmd_reg
    import lpddr4_cmd_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    input  cmd_payload_t         cmd,
    output logic                 dfi_cs_n,
    output logic                 dfi_ras_n,
    output logic                 dfi_cas_n,
    output logic                 dfi_we_n,
    output logic [MC_ADDR_W-1:0] dfi_address,
    output logic [MC_BA_W-1:0]   dfi_bank
);

    dfi_cmd_t             dfi_cmd;
    logic [MC_ADDR_W-1:0] address;
    logic [MC_BA_W-1:0]   bank;

    // Capture the accepted command, or fall back to NOP with address/bank held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dfi_cmd <= DFI_NOP;
            address <= '0;
            bank    <= '0;
        end else if (issue) begin
            dfi_cmd <= encode_dfi_cmd(cmd);
            address <= cmd.a;
            bank    <= cmd.ba;
        end else begin
            dfi_cmd <= DFI_NOP;
        end
    end

    assign dfi_cs_n    = dfi_cmd.cs_n;
    assign dfi_ras_n   = dfi_cmd.ras_n;
    assign dfi_cas_n   = dfi_cmd.cas_n;
    assign dfi_we_n    = dfi_cmd.we_n;
    assign dfi_address = address;
    assign dfi_bank    = bank;

endmodule

// File: rtl/lpddr4_cmd_arbiter.sv
// Refresh / bank-machine command arbiter. Refresh wins whenever the slot is
// free, but a granted read/write burst always runs to its last beat. The
// winning command goes to the PHY through a one-cycle registered DFI stage.
module lpddr4_cmd_arbiter
    import lpddr4_cmd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MC_ADDR_W,
    parameter int BA_W       = MC_BA_W,
    parameter int WAIT_CNT_W = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  ref_cmd_valid,
    output logic                  ref_cmd_ready,
    input  logic                  ref_cmd_last,
    input  logic [ADDR_W-1:0]     ref_cmd_payload_a,
    input  logic [BA_W-1:0]       ref_cmd_payload_ba,
    input  logic                  ref_cmd_payload_cas,
    input  logic                  ref_cmd_payload_ras,
    input  logic                  ref_cmd_payload_we,

    input  logic                  rw_cmd_valid,
    output logic                  rw_cmd_ready,
    input  logic                  rw_cmd_last,
    input  logic [ADDR_W-1:0]     rw_cmd_payload_a,
    input  logic [BA_W-1:0]       rw_cmd_payload_ba,
    input  logic                  rw_cmd_payload_cas,
    input  logic                  rw_cmd_payload_ras,
    input  logic                  rw_cmd_payload_we,

    output logic                  dfi_cs_n,
    output logic                  dfi_ras_n,
    output logic                  dfi_cas_n,
    output logic                  dfi_we_n,
    output logic [ADDR_W-1:0]     dfi_address,
    output logic [BA_W-1:0]       dfi_bank,

    output logic                  ref_active,
    output logic [WAIT_CNT_W-1:0] ref_wait_cnt
);

    arb_state_t            state;
    arb_state_t            next_state;
    logic                  ref_hs;
    logic                  rw_hs;
    cmd_payload_t          sel_cmd;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Readies are decoded from the registered state only, never from valids.
    assign ref_cmd_ready = (state == REF);
    assign rw_cmd_ready  = (state == RW);
    assign ref_active    = (state == REF);
    assign ref_hs        = ref_cmd_valid & ref_cmd_ready;
    assign rw_hs         = rw_cmd_valid & rw_cmd_ready;
    assign ref_wait_cnt  = wait_cnt;

    // Grant state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision; grants only change at the end of a sequence/burst.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ref_cmd_valid) begin
                    next_state = REF;
                end else if (rw_cmd_valid) begin
                    next_state = RW;
                end else begin
                    next_state = IDLE;
                end
            end
            REF: begin
                // The bank machines get one burst between back-to-back refreshes.
                if (ref_hs && ref_cmd_last) begin
                    if (rw_cmd_valid) begin
                        next_state = RW;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_state = REF;
                end
            end
            RW: begin
                // rw_cmd_valid is high on its own handshake, so with no refresh
                // pending the grant stays with the bank machines.
                if (rw_hs && rw_cmd_last) begin
                    if (ref_cmd_valid) begin
                        next_state = REF;
                    end else if (rw_cmd_valid) begin
                        next_state = RW;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_state = RW;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Select the payload of the stream that currently owns the slot.
    always_comb begin
        sel_cmd = '0;
        if (state == REF) begin
            sel_cmd.a   = ref_cmd_payload_a;
            sel_cmd.ba  = ref_cmd_payload_ba;
            sel_cmd.cas = ref_cmd_payload_cas;
            sel_cmd.ras = ref_cmd_payload_ras;
            sel_cmd.we  = ref_cmd_payload_we;
        end else begin
            sel_cmd.a   = rw_cmd_payload_a;
            sel_cmd.ba  = rw_cmd_payload_ba;
            sel_cmd.cas = rw_cmd_payload_cas;
            sel_cmd.ras = rw_cmd_payload_ras;
            sel_cmd.we  = rw_cmd_payload_we;
        end
    end

    // Saturating count of cycles a refresh request waits without the grant.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wait_cnt <= '0;
        end else if (state == REF) begin
            wait_cnt <= '0;
        end else if (ref_cmd_valid && (wait_cnt != {WAIT_CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end else begin
            wait_cnt <= wait_cnt;
        end
    end

    lpddr4_dfi_cmd_reg u_dfi_cmd_reg (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .issue       (ref_hs | rw_hs),
        .cmd         (sel_cmd),
        .dfi_cs_n    (dfi_cs_n),
        .dfi_ras_n   (dfi_ras_n),
        .dfi_cas_n   (dfi_cas_n),
        .dfi_we_n    (dfi_we_n),
        .dfi_address (dfi_address),
        .dfi_bank    (dfi_bank)
    );

endmodule

// File: tb/tb_lpddr4_cmd_arbiter.sv
// Self-checking bench for lpddr4_cmd_arbiter: directed scenarios plus
// randomized traffic, all compared against a behavioural grant model.
module tb_lpddr4_cmd_arbiter;

    localparam int OWN_IDLE = 0;
    localparam int OWN_REF  = 1;
    localparam int OWN_RW   = 2;

    logic        sys_clk;
    logic        sys_rst;
    logic        ref_cmd_valid, ref_cmd_ready, ref_cmd_last;
    logic [16:0] ref_cmd_payload_a;
    logic [2:0]  ref_cmd_payload_ba;
    logic        ref_cmd_payload_cas, ref_cmd_payload_ras, ref_cmd_payload_we;
    logic        rw_cmd_valid, rw_cmd_ready, rw_cmd_last;
    logic [16:0] rw_cmd_payload_a;
    logic [2:0]  rw_cmd_payload_ba;
    logic        rw_cmd_payload_cas, rw_cmd_payload_ras, rw_cmd_payload_we;
    logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [16:0] dfi_address;
    logic [2:0]  dfi_bank;
    logic        ref_active;
    logic [7:0]  ref_wait_cnt;

    // Reference model: who owns the slot and what the DFI bus must show.
    int          m_owner;
    logic [3:0]  m_cmd;
    logic [16:0] m_addr;
    logic [2:0]  m_bank;
    int          m_wait;

    int n_checks;
    int n_errors;

    lpddr4_cmd_arbiter dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .ref_cmd_valid       (ref_cmd_valid),
        .ref_cmd_ready       (ref_cmd_ready),
        .ref_cmd_last        (ref_cmd_last),
        .ref_cmd_payload_a   (ref_cmd_payload_a),
        .ref_cmd_payload_ba  (ref_cmd_payload_ba),
        .ref_cmd_payload_cas (ref_cmd_payload_cas),
        .ref_cmd_payload_ras (ref_cmd_payload_ras),
        .ref_cmd_payload_we  (ref_cmd_payload_we),
        .rw_cmd_valid        (rw_cmd_valid),
        .rw_cmd_ready        (rw_cmd_ready),
        .rw_cmd_last         (rw_cmd_last),
        .rw_cmd_payload_a    (rw_cmd_payload_a),
        .rw_cmd_payload_ba   (rw_cmd_payload_ba),
        .rw_cmd_payload_cas  (rw_cmd_payload_cas),
        .rw_cmd_payload_ras  (rw_cmd_payload_ras),
        .rw_cmd_payload_we   (rw_cmd_payload_we),
        .dfi_cs_n            (dfi_cs_n),
        .dfi_ras_n           (dfi_ras_n),
        .dfi_cas_n           (dfi_cas_n),
        .dfi_we_n            (dfi_we_n),
        .dfi_address         (dfi_address),
        .dfi_bank            (dfi_bank),
        .ref_active          (ref_active),
        .ref_wait_cnt        (ref_wait_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("ref_ready",  32'(ref_cmd_ready), 32'(m_owner == OWN_REF));
        check_val("rw_ready",   32'(rw_cmd_ready),  32'(m_owner == OWN_RW));
        check_val("ref_active", 32'(ref_active),    32'(m_owner == OWN_REF));
        check_val("dfi_cmd",    32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'(m_cmd));
        check_val("dfi_addr",   32'(dfi_address),   32'(m_addr));
        check_val("dfi_bank",   32'(dfi_bank),      32'(m_bank));
        check_val("wait_cnt",   32'(ref_wait_cnt),  m_wait);
    endtask

    task automatic model_reset();
        m_owner = OWN_IDLE;
        m_cmd   = 4'hF;
        m_addr  = 17'd0;
        m_bank  = 3'd0;
        m_wait  = 0;
    endtask

    // One clock: predict from the current inputs, take the edge, compare.
    task automatic clk_cycle();
        logic ref_acc, rw_acc;
        int   nxt;
        ref_acc = (m_owner == OWN_REF) && ref_cmd_valid;
        rw_acc  = (m_owner == OWN_RW) && rw_cmd_valid;
        nxt = m_owner;
        if (m_owner == OWN_IDLE) begin
            nxt = ref_cmd_valid ? OWN_REF : (rw_cmd_valid ? OWN_RW : OWN_IDLE);
        end else if (m_owner == OWN_REF) begin
            if (ref_acc && ref_cmd_last) nxt = rw_cmd_valid ? OWN_RW : OWN_IDLE;
        end else begin
            if (rw_acc && rw_cmd_last)
                nxt = ref_cmd_valid ? OWN_REF : (rw_cmd_valid ? OWN_RW : OWN_IDLE);
        end
        @(posedge sys_clk);
        #1;
        if (ref_acc) begin
            m_cmd  = {1'b0, ~ref_cmd_payload_ras, ~ref_cmd_payload_cas, ~ref_cmd_payload_we};
            m_addr = ref_cmd_payload_a;
            m_bank = ref_cmd_payload_ba;
        end else if (rw_acc) begin
            m_cmd  = {1'b0, ~rw_cmd_payload_ras, ~rw_cmd_payload_cas, ~rw_cmd_payload_we};
            m_addr = rw_cmd_payload_a;
            m_bank = rw_cmd_payload_ba;
        end else begin
            m_cmd = 4'hF;
        end
        if (m_owner == OWN_REF) m_wait = 0;
        else if (ref_cmd_valid) m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
        m_owner = nxt;
        check_all();
    endtask

    task automatic set_ref(input logic v, input logic l, input logic [16:0] a, input logic [2:0] ba,
                           input logic cas, input logic ras, input logic we);
        ref_cmd_valid = v; ref_cmd_last = l; ref_cmd_payload_a = a; ref_cmd_payload_ba = ba;
        ref_cmd_payload_cas = cas; ref_cmd_payload_ras = ras; ref_cmd_payload_we = we;
    endtask

    task automatic set_rw(input logic v, input logic l, input logic [16:0] a, input logic [2:0] ba,
                          input logic cas, input logic ras, input logic we);
        rw_cmd_valid = v; rw_cmd_last = l; rw_cmd_payload_a = a; rw_cmd_payload_ba = ba;
        rw_cmd_payload_cas = cas; rw_cmd_payload_ras = ras; rw_cmd_payload_we = we;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sys_rst = 1'b1;
        set_ref(1'b0, 1'b0, 17'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_rw(1'b0, 1'b0, 17'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        // Reset state.
        check_val("rst_cmd", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'hF);
        check_val("rst_addr", 32'(dfi_address), 32'd0);
        check_val("rst_readies", 32'({ref_cmd_ready, rw_cmd_ready}), 32'd0);
        check_val("rst_wait", 32'(ref_wait_cnt), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check_all();

        // Single RW command: one command, then NOP with address held.
        set_rw(1'b1, 1'b1, 17'h1234, 3'd5, 1'b1, 1'b0, 1'b0);
        clk_cycle();
        check_val("single_grant_nop", 32'(dfi_cs_n), 32'd1);
        clk_cycle();
        check_val("single_cmd", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'b0101);
        check_val("single_bank", 32'(dfi_bank), 32'd5);
        check_val("single_addr", 32'(dfi_address), 32'h1234);
        set_rw(1'b0, 1'b0, 17'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        clk_cycle();
        check_val("single_after_nop", 32'(dfi_cs_n), 32'd1);
        check_val("single_addr_hold", 32'(dfi_address), 32'h1234);

        // 4-beat RW burst, refresh request arriving at beat 2.
        for (int b = 1; b <= 4; b++) begin
            set_rw(1'b1, (b == 4), 17'(b * 17'h111), 3'(b), 1'b1, 1'b0, b[0]);
            if (b >= 2) set_ref(1'b1, 1'b0, 17'h400, 3'd0, 1'b0, 1'b1, 1'b1);
            clk_cycle();
            check_val("burst_beat_issued", 32'(dfi_cs_n), 32'd0);
            check_val("burst_no_preempt", 32'(ref_cmd_ready), (b == 4) ? 32'd1 : 32'd0);
        end
        check_val("burst_wait3", 32'(ref_wait_cnt), 32'd3);

        // Refresher holds valid without last (and once drops it): REF is held.
        set_rw(1'b0, 1'b0, 17'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            set_ref((k != 2), 1'b0, 17'h400, 3'd0, 1'b0, 1'b1, 1'b1);
            clk_cycle();
            check_val("hold_ref_ready", 32'(ref_cmd_ready), 32'd1);
            check_val("hold_rw_ready", 32'(rw_cmd_ready), 32'd0);
        end
        check_val("wait_cleared", 32'(ref_wait_cnt), 32'd0);
        set_ref(1'b1, 1'b1, 17'h0, 3'd0, 1'b1, 1'b1, 1'b0);
        clk_cycle();
        set_ref(1'b0, 1'b0, 17'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        clk_cycle();

        // Both request in IDLE: refresh wins, PREA then REF, then RW granted.
        set_ref(1'b1, 1'b0, 17'h400, 3'd0, 1'b0, 1'b1, 1'b1);
        set_rw(1'b1, 1'b0, 17'h0ABC, 3'd2, 1'b1, 1'b0, 1'b1);
        clk_cycle();
        check_val("both_ref_wins", 32'({ref_cmd_ready, rw_cmd_ready}), 32'b10);
        clk_cycle();
        check_val("prea_cmd", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'b0010);
        check_val("prea_a10", 32'(dfi_address[10]), 32'd1);
        set_ref(1'b1, 1'b1, 17'h0, 3'd0, 1'b1, 1'b1, 1'b0);
        clk_cycle();
        check_val("ref_cmd", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'b0001);
        check_val("after_ref_rw", 32'(rw_cmd_ready), 32'd1);

        // Long RW burst with refresh waiting: counter saturates at 255.
        set_ref(1'b1, 1'b0, 17'h400, 3'd0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            set_rw(1'b1, 1'b0, 17'($urandom), 3'($urandom), 1'($urandom), 1'b0, 1'($urandom));
            clk_cycle();
        end
        check_val("wait_saturated", 32'(ref_wait_cnt), 32'd255);
        set_rw(1'b1, 1'b1, 17'h7, 3'd1, 1'b1, 1'b0, 1'b0);
        clk_cycle();
        check_val("wait_sat_hold", 32'(ref_wait_cnt), 32'd255);
        set_ref(1'b1, 1'b1, 17'h0, 3'd0, 1'b1, 1'b1, 1'b0);
        clk_cycle();
        check_val("wait_clear_in_ref", 32'(ref_wait_cnt), 32'd0);

        // Randomized traffic checked against the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            set_ref(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 17'($urandom),
                    3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            set_rw(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), 17'($urandom),
                   3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            clk_cycle();
        end

        // Drive into REF with a command on the bus, then reset asynchronously.
        set_ref(1'b1, 1'b0, 17'h400, 3'd0, 1'b0, 1'b1, 1'b1);
        set_rw(1'b1, 1'b1, 17'h55, 3'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 400 && m_owner != OWN_REF; k++) begin
            clk_cycle();
        end
        check_val("reach_ref", 32'(m_owner == OWN_REF), 32'd1);
        clk_cycle();
        check_val("pre_reset_cmd", 32'(dfi_cs_n), 32'd0);
        sys_rst = 1'b1;
        #1;
        check_val("async_rst_cmd", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'hF);
        check_val("async_rst_ready", 32'({ref_cmd_ready, rw_cmd_ready}), 32'd0);
        check_val("async_rst_active", 32'(ref_active), 32'd0);
        model_reset();
        check_all();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        set_ref(1'b0, 1'b0, 17'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_rw(1'b0, 1'b0, 17'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_all();
        clk_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
